// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS32 pipeline: mem wait, MDU occupancy, taken branch, load-use.
// Optional perf counters are enabled with `define HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned REG_AW  = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mdu_start,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              stall_idex,
  output logic              stall_exmem,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic              flush_memwb,
  output logic              mdu_busy,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned CNT_INIT  = (MDU_LAT > 1) ? MDU_LAT - 2 : 0;
  localparam bit          MDU_MULTI = (MDU_LAT > 1);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic mem_wait;
  logic mdu_hold;
  logic load_use;
  logic rule_branch;

  // Hazard detection terms; a branch coinciding with an MDU start is illegal decode and ignored.
  assign mem_wait = mem_req && !mem_ready;
  assign mdu_hold = ((state == MDU_WAIT) && (cnt != '0)) ||
                    ((state == RUN) && ex_mdu_start && MDU_MULTI);
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign rule_branch = !Reset && !mem_wait && !mdu_hold && ex_branch_taken && !ex_mdu_start;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= RUN;
      cnt      <= '0;
      mdu_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mdu_busy <= (state_nxt == MDU_WAIT);
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    if (!Reset) begin
      if (mem_wait) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        flush_memwb = 1'b1;
      end else if (mdu_hold) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        flush_exmem = 1'b1;
      end else if (rule_branch) begin
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
      end else if (load_use) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        flush_idex  = 1'b1;
      end

      // The whole pipeline (and this FSM) is frozen while data memory is busy.
      if (!mem_wait) begin
        case (state)
          RUN: begin
            if (ex_mdu_start && MDU_MULTI) begin
              state_nxt = MDU_WAIT;
              cnt_nxt   = CNT_W'(CNT_INIT);
            end
          end
          MDU_WAIT: begin
            if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
            else           state_nxt = RUN;
          end
          default: state_nxt = RUN;
        endcase
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_pc)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (rule_branch) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MDU_LAT=4), with or without HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_memread, ex_mdu_start, ex_branch_taken;
  logic       mem_req, mem_ready;
  logic       stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic       flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic       mdu_busy;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  // {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_exmem, flush_memwb}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] MEMW = 8'b1111_0001;
  localparam logic [7:0] MDU  = 8'b1110_0010;
  localparam logic [7:0] BR   = 8'b0000_1100;
  localparam logic [7:0] LU   = 8'b1100_0100;

  logic [7:0] outs;
  assign outs = {stall_pc, stall_ifid, stall_idex, stall_exmem,
                 flush_ifid, flush_idex, flush_exmem, flush_memwb};

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  pipe_hazard_ctrl #(.MDU_LAT(4), .REG_AW(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_mdu_start(ex_mdu_start),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb), .mdu_busy(mdu_busy),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
    ex_mdu_start = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Advance one clock; e is the expected output vector of the cycle being closed.
  task automatic tick(input logic [7:0] e);
    if (!Reset) begin
      exp_stall += 32'(e[7]);
      if (e == BR) exp_flush += 1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic check_perf(input string tag);
    logic [31:0] es, ef;
`ifdef HAZ_PERF_CNT_EN
    es = exp_stall; ef = exp_flush;
`else
    es = 32'd0; ef = 32'd0;
`endif
    n_tests++;
    if (perf_stall_cnt !== es) begin
      n_fail++;
      $display("FAIL %s perf_stall_cnt got %0d want %0d", tag, perf_stall_cnt, es);
    end
    n_tests++;
    if (perf_flush_cnt !== ef) begin
      n_fail++;
      $display("FAIL %s perf_flush_cnt got %0d want %0d", tag, perf_flush_cnt, ef);
    end
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b1;
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    tick(NONE); tick(NONE);
    #1;
    n_tests++;
    if (outs !== NONE) begin
      n_fail++; $display("FAIL reset_outs got %b want %b", outs, NONE);
    end
    idle();
    Reset = 1'b0;
    exp_stall = 0; exp_flush = 0;
    #1;
    n_tests++;
    if (mdu_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mdu_busy got %b want 0", mdu_busy);
    end
    n_tests++;
    if (outs !== NONE) begin
      n_fail++; $display("FAIL reset_idle_outs got %b want %b", outs, NONE);
    end
    check_perf("reset");
    tick(NONE);
  endtask

  task automatic test_load_use();
    idle();
    ex_memread = 1'b1; ex_rd = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8; #1;
    n_tests++;
    if (outs !== LU) begin n_fail++; $display("FAIL lu_rs got %b want %b", outs, LU); end
    ex_rd = 5'd0; id_rs = 5'd0; #1;
    n_tests++;
    if (outs !== NONE) begin n_fail++; $display("FAIL lu_r0 got %b want %b", outs, NONE); end
    ex_rd = 5'd8; id_rs = 5'd3; id_uses_rt = 1'b1; id_rt = 5'd8; #1;
    n_tests++;
    if (outs !== LU) begin n_fail++; $display("FAIL lu_rt got %b want %b", outs, LU); end
    id_uses_rt = 1'b0; #1;
    n_tests++;
    if (outs !== NONE) begin n_fail++; $display("FAIL lu_unused got %b want %b", outs, NONE); end
    id_uses_rt = 1'b1; ex_memread = 1'b0; #1;
    n_tests++;
    if (outs !== NONE) begin n_fail++; $display("FAIL lu_noload got %b want %b", outs, NONE); end
    ex_memread = 1'b1; #1;
    tick(LU);
    idle(); #1;
    tick(NONE);
    check_perf("load_use");
  endtask

  task automatic test_mdu();
    logic [7:0] e;
    logic       b;
    idle();
    ex_mdu_start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) ex_mdu_start = 1'b0;
      #1;
      e = (c < 3) ? MDU : NONE;
      b = (c >= 1 && c <= 3);
      n_tests++;
      if (outs !== e) begin n_fail++; $display("FAIL mdu_outs c%0d got %b want %b", c, outs, e); end
      n_tests++;
      if (mdu_busy !== b) begin n_fail++; $display("FAIL mdu_busy c%0d got %b want %b", c, mdu_busy, b); end
      tick(e);
    end
    check_perf("mdu");
  endtask

  task automatic test_mem_wait();
    idle();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (outs !== MEMW) begin n_fail++; $display("FAIL memw c%0d got %b want %b", c, outs, MEMW); end
      tick(MEMW);
    end
    mem_ready = 1'b1; #1;
    n_tests++;
    if (outs !== NONE) begin n_fail++; $display("FAIL memw_ready got %b want %b", outs, NONE); end
    tick(NONE);
    idle();
    check_perf("mem_wait");
  endtask

  task automatic test_mdu_mem_wait();
    logic [7:0] exp_o [7];
    logic [6:0] exp_b;
    exp_o = '{MDU, MDU, MEMW, MEMW, MDU, NONE, NONE};
    exp_b = 7'b0111110;
    idle();
    ex_mdu_start = 1'b1;
    for (int c = 0; c < 7; c++) begin
      mem_req = (c == 2 || c == 3); mem_ready = 1'b0;
      if (c == 6) ex_mdu_start = 1'b0;
      #1;
      n_tests++;
      if (outs !== exp_o[c]) begin n_fail++; $display("FAIL mdu_memw c%0d got %b want %b", c, outs, exp_o[c]); end
      n_tests++;
      if (mdu_busy !== exp_b[6-c]) begin n_fail++; $display("FAIL mdu_memw_busy c%0d got %b want %b", c, mdu_busy, exp_b[6-c]); end
      tick(exp_o[c]);
    end
    idle();
    check_perf("mdu_mem_wait");
  endtask

  task automatic test_mdu_deferred();
    logic [7:0] exp_o [6];
    logic [5:0] exp_b;
    exp_o = '{MEMW, MDU, MDU, MDU, NONE, NONE};
    exp_b = 6'b001110;
    idle();
    ex_mdu_start = 1'b1; mem_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      mem_ready = (c != 0);
      if (c == 5) ex_mdu_start = 1'b0;
      #1;
      n_tests++;
      if (outs !== exp_o[c]) begin n_fail++; $display("FAIL mdu_defer c%0d got %b want %b", c, outs, exp_o[c]); end
      n_tests++;
      if (mdu_busy !== exp_b[5-c]) begin n_fail++; $display("FAIL mdu_defer_busy c%0d got %b want %b", c, mdu_busy, exp_b[5-c]); end
      tick(exp_o[c]);
    end
    idle();
    check_perf("mdu_deferred");
  endtask

  task automatic test_branch();
    idle();
    ex_branch_taken = 1'b1;
    ex_memread = 1'b1; ex_rd = 5'd9; id_uses_rt = 1'b1; id_rt = 5'd9; #1;
    n_tests++;
    if (outs !== BR) begin n_fail++; $display("FAIL br_lu got %b want %b", outs, BR); end
    tick(BR);
    idle(); #1;
    check_perf("branch");
    ex_branch_taken = 1'b1; ex_mdu_start = 1'b1; #1;
    n_tests++;
    if (outs !== MDU) begin n_fail++; $display("FAIL br_mdu got %b want %b", outs, MDU); end
    tick(MDU);
    ex_branch_taken = 1'b0;
    tick(MDU); tick(MDU);
    #1;
    n_tests++;
    if (outs !== NONE) begin n_fail++; $display("FAIL br_mdu_release got %b want %b", outs, NONE); end
    tick(NONE);
    idle(); #1;
    check_perf("branch_mdu");
  endtask

  task automatic test_reset_mid_mdu();
    idle();
    ex_mdu_start = 1'b1; #1;
    tick(MDU);
    Reset = 1'b1; #1;
    n_tests++;
    if (outs !== NONE) begin n_fail++; $display("FAIL rstmdu_during got %b want %b", outs, NONE); end
    tick(NONE);
    Reset = 1'b0;
    idle();
    exp_stall = 0; exp_flush = 0;
    #1;
    n_tests++;
    if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL rstmdu_busy got %b want 0", mdu_busy); end
    n_tests++;
    if (outs !== NONE) begin n_fail++; $display("FAIL rstmdu_outs got %b want %b", outs, NONE); end
    check_perf("reset_mid_mdu");
    tick(NONE);
    #1;
    n_tests++;
    if (outs !== NONE) begin n_fail++; $display("FAIL rstmdu_after got %b want %b", outs, NONE); end
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    #1;
    test_reset();
    test_load_use();
    test_mdu();
    test_mem_wait();
    test_mdu_mem_wait();
    test_mdu_deferred();
    test_branch();
    test_reset_mid_mdu();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS32 core pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves four hazard classes: data-memory wait, multicycle MUL/DIV occupancy of EX, taken branch/jump in EX, and load-use.
- Drives per-register stall and flush lines. Pipeline registers give stall priority over flush, and a bubble is a flush with stall=0.
- One instance per core.

Parameters:
MDU_LAT, 4, total cycles a MUL/DIV op occupies EX (legal 1..16)
REG_AW, 5, register-specifier width

Ports:
Clk  in  1  clock
Reset  in  1  synchronous active-high reset
id_rs  in  REG_AW  rs specifier of instruction in ID
id_rt  in  REG_AW  rt specifier of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  EX instruction is a load
ex_rd  in  REG_AW  destination of EX instruction
ex_mdu_start  in  1  EX holds a multicycle MUL/DIV op
ex_branch_taken  in  1  branch/jump in EX resolved taken
mem_req  in  1  MEM-stage instruction accesses data memory
mem_ready  in  1  data memory completes access this cycle
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID
stall_idex  out  1  hold ID/EX
stall_exmem  out  1  hold EX/MEM
flush_ifid  out  1  zero IF/ID
flush_idex  out  1  zero ID/EX
flush_exmem  out  1  zero EX/MEM
flush_memwb  out  1  zero MEM/WB
mdu_busy  out  1  registered; 1 while state==MDU_WAIT
perf_stall_cnt  out  32  stall-cycle counter (see Optional Feature)
perf_flush_cnt  out  32  branch-flush counter (see Optional Feature)

Behaviour:
- Clock, reset and state:
  - Single clock Clk. Reset is synchronous, active-high.
  - FSM states: RUN, MDU_WAIT. Counter cnt is 4 bits.
  - Reset (sampled at posedge) forces state=RUN, cnt=0, mdu_busy=0, perf counters=0.
  - While Reset is high, all stall/flush outputs are 0.
- Outputs are combinational from state and inputs, evaluated in this priority order (first match wins, all unlisted stall/flush = 0):
  1. Mem wait: mem_req && !mem_ready.
     - Stall pc, ifid, idex, exmem; flush_memwb=1 (bubble into WB).
     - FSM state and cnt frozen.
  2. MDU hold: (state==MDU_WAIT && cnt!=0) or (state==RUN && ex_mdu_start && MDU_LAT>1).
     - Stall pc, ifid, idex; flush_exmem=1.
  3. Branch: ex_branch_taken.
     - flush_ifid=1, flush_idex=1, no stalls.
     - A coincident load-use is discarded because the ID instruction is squashed.
  4. Load-use: ex_memread && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
     - Stall pc, ifid; flush_idex=1.
- FSM transitions (only when there is no mem wait):
  - RUN → MDU_WAIT when ex_mdu_start && MDU_LAT>1; cnt <= MDU_LAT-2.
  - MDU_WAIT with cnt!=0: cnt <= cnt-1.
  - MDU_WAIT with cnt==0: release cycle. Nothing stalled, ID/EX and EX/MEM advance, next state RUN.
  - In MDU_WAIT, ex_mdu_start is ignored because the same op is still in EX.
- MDU latency: an MDU op causes exactly MDU_LAT-1 front-end stall cycles, plus any mem-wait cycles overlapping it. MDU_LAT=1 never leaves RUN.
- Mem wait arriving in the same cycle as ex_mdu_start in RUN: the MDU start is deferred. ex_mdu_start stays high because EX is frozen, and the FSM starts on the first cycle mem_ready is seen.
- ex_branch_taken and ex_mdu_start together is illegal decode. MDU handling wins and the branch is ignored.
- Reset mid-MDU_WAIT returns to RUN with no residual stall on the following cycle.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined:
  - perf_stall_cnt increments every non-reset cycle in which stall_pc=1.
  - perf_flush_cnt increments every cycle in which rule 3 fires.
  - Both counters are 32-bit, wrap modulo 2^32, and reset to 0.
- When undefined: both ports are tied to 32'd0 and no counter flops are synthesized.

Test Plan:
1. Load-use: ex_memread=1, ex_rd=8, id_uses_rs=1, id_rs=8 → stall_pc=stall_ifid=flush_idex=1, others 0. The same stimulus with ex_rd=0 → all 0.
2. MDU with MDU_LAT=4: ex_mdu_start high from cycle 0.
   - stall_pc=1 and flush_exmem=1 on cycles 0–2; mdu_busy=1 on cycles 1–3.
   - Cycle 3 is the release cycle (all 0); cycle 4 state=RUN.
3. Mem wait: mem_req=1, mem_ready=0 for 3 cycles → stall pc/ifid/idex/exmem=1 and flush_memwb=1 for those 3 cycles. The 4th cycle (ready=1) → all 0.
4. Mem wait during MDU_WAIT (cnt=1) for 2 cycles → cnt holds at 1. Release occurs 2 cycles later than in scenario 2; mdu_busy stays 1 throughout.
5. Branch + load-use together → flush_ifid=flush_idex=1, stall_pc=0. With HAZ_PERF_CNT_EN, perf_flush_cnt goes 0→1.
6. Reset asserted in cycle 1 of scenario 2 → next cycle state=RUN, mdu_busy=0, perf counters=0, all outputs 0 with inputs idle.
